// File: rtl/hour_display_driver_pkg.sv
// Shared definitions for the 12-hour display driver: count limits, BCD mapping,
// active-high 7-segment encodings and the small enums used to steer the decoder.
package hour_display_driver_pkg;

    localparam logic [3:0] HOUR_MAX  = 4'd11;
    localparam logic [7:0] HOUR_RST  = 8'h12;

    // Segment vectors are {g,f,e,d,c,b,a}, 1 = lit.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

    typedef enum logic [1:0] {
        SEG_MODE_DIGIT = 2'd0,
        SEG_MODE_BLANK = 2'd1,
        SEG_MODE_DASH  = 2'd2
    } seg_mode_e;

    function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Upstream count 0..11 maps to the clock face 12,1..11 in BCD.
    function automatic logic [7:0] count_to_bcd(input logic [3:0] count);
        logic [7:0] bcd;
        case (count)
            4'd0:    bcd = 8'h12;
            4'd10:   bcd = 8'h10;
            4'd11:   bcd = 8'h11;
            default: bcd = {4'd0, count};
        endcase
        return bcd;
    endfunction

endpackage

// File: rtl/hour_display_driver_seg7_encode.sv
// Combinational BCD digit to active-high 7-segment pattern, with blank and dash
// overrides selected by the caller.
module seg7_encode
    import hour_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  seg_mode_e  mode,
    output logic [6:0] seg
);

    // NOTE: always_comb assigns a default first so every path drives seg and
    // no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        case (mode)
            SEG_MODE_DIGIT: seg = seg7_digit(digit);
            SEG_MODE_DASH:  seg = SEG_DASH;
            default:        seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hour_display_driver.sv
// Converts the mod-12 hour count to a BCD clock hour with AM/PM tracking and
// drives a two-digit multiplexed 7-segment display.
module hour_display_driver
    import hour_display_driver_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       err,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int          SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // XOR masks turn active-high values into the pad polarity; an all-zero
    // active-high value therefore doubles as the "dark" reset value.
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic       DP_POL  = SEG_ACTIVE_LOW;
    localparam logic [1:0] AN_POL  = {2{SEG_ACTIVE_LOW}};

    logic [3:0]        count_q;
    logic [SCAN_W-1:0] scan_cnt;
    slot_e             sel;

    logic              count_valid;
    logic              wrap;
    logic [3:0]        digit;
    seg_mode_e         mode;
    logic [6:0]        seg_raw;
    logic              dp_raw;
    logic [1:0]        an_raw;

    assign count_valid = (count <= HOUR_MAX);
    // Only a genuine 11 -> 0 step is a new half-day; loads to 0 are not.
    assign wrap        = (count_q == HOUR_MAX) && (count == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 4'd0;
            hour_bcd <= HOUR_RST;
            pm       <= 1'b0;
            err      <= 1'b0;
        end else begin
            count_q <= count;
            err     <= !count_valid;
            if (count_valid) begin
                hour_bcd <= count_to_bcd(count);
            end
            if (wrap) begin
                pm <= !pm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= SLOT_UNITS;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= (sel == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        digit  = hour_bcd[3:0];
        mode   = SEG_MODE_DIGIT;
        dp_raw = 1'b0;
        an_raw = 2'b01;
        if (sel == SLOT_TENS) begin
            digit  = hour_bcd[7:4];
            an_raw = 2'b10;
        end else begin
            dp_raw = pm;
        end
        // Dash wins over leading-zero blanking so an error is visible on both digits.
        if (err) begin
            mode = SEG_MODE_DASH;
        end else if (sel == SLOT_TENS && digit == 4'd0) begin
            mode = SEG_MODE_BLANK;
        end
    end

    seg7_encode u_seg7_encode (
        .digit (digit),
        .mode  (mode),
        .seg   (seg_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_POL;
            dp  <= DP_POL;
            an  <= AN_POL;
        end else begin
            seg <= seg_raw ^ SEG_POL;
            dp  <= dp_raw ^ DP_POL;
            an  <= an_raw ^ AN_POL;
        end
    end

endmodule
